// File: rtl/adder_tree_feeder_pkg.sv
// Shared definitions for the tree-adder family: operand width and the
// feeder's handshake state encoding.
package adder_tree_feeder_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/adder_tree_feeder_tracker.sv
// Finish-edge detector and bounded wait counter for one adder-tree run.
// Armed by the start pulse; reports either a fresh finish rise or a timeout.
module tree_handshake_tracker #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic tree_finish,
    output logic done,
    output logic timeout
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic          r_finish_q;
    logic          r_active;
    logic [TW-1:0] r_wait_cnt;
    logic          w_fin_rise;
    logic          w_expired;

    // A finish level left over from the previous run is not a rise, so it
    // cannot complete the new run.
    assign w_fin_rise = tree_finish & ~r_finish_q;
    assign w_expired  = (r_wait_cnt == TW'(TIMEOUT - 1));
    assign done       = r_active & w_fin_rise;
    assign timeout    = r_active & ~w_fin_rise & w_expired;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_finish_q <= 1'b0;
            r_active   <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_finish_q <= tree_finish;
            if (arm) begin
                r_active   <= 1'b1;
                r_wait_cnt <= '0;
            end else if (done || timeout) begin
                r_active   <= 1'b0;
                r_wait_cnt <= '0;
            end else if (r_active) begin
                r_wait_cnt <= r_wait_cnt + TW'(1);
            end
        end
    end

endmodule

// File: rtl/adder_tree_feeder.sv
// Serial-to-parallel operand loader and start/finish initiator for an
// NI-input adder tree; returns the tree's sum over a valid/ready port.
module adder_tree_feeder
    import adder_tree_feeder_pkg::*;
#(
    parameter int NI      = 128,
    parameter int TIMEOUT = 1024,
    parameter int CW      = $clog2(NI)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WORD_W-1:0]    in_data,
    output logic                 in_ready,
    output logic [NI*WORD_W-1:0] tree_inputs,
    output logic                 tree_start,
    input  logic [WORD_W-1:0]    tree_summation,
    input  logic                 tree_finish,
    output logic [WORD_W-1:0]    result,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 timeout_err
);

    state_t                r_state;
    state_t                w_next_state;
    logic [CW-1:0]         r_cnt;
    logic [NI*WORD_W-1:0]  r_tree_inputs;
    logic [WORD_W-1:0]     r_result;
    logic                  r_result_valid;
    logic                  r_timeout_err;
    logic                  w_accept;
    logic                  w_last_word;
    logic                  w_done;
    logic                  w_timeout;

    assign in_ready     = (r_state == LOAD) && !rst;
    assign w_accept     = in_valid && in_ready;
    assign w_last_word  = (r_cnt == CW'(NI - 1));
    assign tree_start   = (r_state == START);
    assign tree_inputs  = r_tree_inputs;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign timeout_err  = r_timeout_err;

    tree_handshake_tracker #(
        .TIMEOUT (TIMEOUT)
    ) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .arm         (tree_start),
        .tree_finish (tree_finish),
        .done        (w_done),
        .timeout     (w_timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment first means every path assigns
    // w_next_state, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LOAD:    if (w_accept && w_last_word) w_next_state = START;
            START:   w_next_state = WAIT;
            WAIT: begin
                if (w_done)         w_next_state = DONE;
                else if (w_timeout) w_next_state = LOAD;
            end
            DONE:    if (result_ready) w_next_state = LOAD;
            default: w_next_state = LOAD;
        endcase
    end

    // NOTE: the operand bank is cleared by reset as well, so the tree never
    // sees stale operands after a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt          <= '0;
            r_tree_inputs  <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= w_last_word ? '0 : r_cnt + CW'(1);
                // First word lands in the most-significant slot.
                for (int i = 0; i < NI; i++) begin
                    if (r_cnt == CW'(i)) begin
                        r_tree_inputs[WORD_W*(NI-i)-1 -: WORD_W] <= in_data;
                    end
                end
            end

            if (r_state == WAIT && w_done) begin
                r_result       <= tree_summation;
                r_result_valid <= 1'b1;
            end else if (r_state == DONE && result_ready) begin
                r_result_valid <= 1'b0;
            end

            if (r_state == WAIT && w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Directed bench for adder_tree_feeder (NI=4, TIMEOUT=16) with a behavioural
// IEEE-754 adder-tree stub whose finish behaviour is selectable per step.
module tb_adder_tree_feeder;

    localparam int NI      = 4;
    localparam int TIMEOUT = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic [31:0]    in_data = '0;
    logic           in_ready;
    logic [127:0]   tree_inputs;
    logic           tree_start;
    logic [31:0]    tree_summation;
    logic           tree_finish;
    logic [31:0]    result;
    logic           result_valid;
    logic           result_ready = 1'b0;
    logic           timeout_err;

    int checks   = 0;
    int failures = 0;

    // Stub modes: 0 normal, 1 never finishes, 2 keeps leftover finish high.
    int stub_mode = 0;
    logic stub_busy;
    int   stub_k;

    adder_tree_feeder #(
        .NI      (NI),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .tree_inputs    (tree_inputs),
        .tree_start     (tree_start),
        .tree_summation (tree_summation),
        .tree_finish    (tree_finish),
        .result         (result),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real x);
        logic s;
        int   e;
        int   mant;
        if (x == 0.0) return 32'd0;
        s = (x < 0.0);
        if (s) x = -x;
        e = 0;
        while (x >= 2.0) begin x = x / 2.0; e++; end
        while (x < 1.0)  begin x = x * 2.0; e--; end
        mant = $rtoi((x - 1.0) * 8388608.0 + 0.5);
        return {s, 8'(e + 127), 23'(mant)};
    endfunction

    function automatic logic [31:0] tree_sum(input logic [127:0] v);
        real s = 0.0;
        for (int i = 0; i < NI; i++) s = s + f2r(v[32*i +: 32]);
        return r2f(s);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tree_finish    <= 1'b0;
            tree_summation <= '0;
            stub_busy      <= 1'b0;
            stub_k         <= 0;
        end else if (tree_start) begin
            tree_summation <= tree_sum(tree_inputs);
            stub_busy      <= 1'b1;
            stub_k         <= 1;
            if (stub_mode != 2) tree_finish <= 1'b0;
        end else if (stub_busy) begin
            stub_k <= stub_k + 1;
            case (stub_mode)
                0: if (stub_k == 4) begin tree_finish <= 1'b1; stub_busy <= 1'b0; end
                2: begin
                    if (stub_k == 2) tree_finish <= 1'b0;
                    else if (stub_k == 5) begin tree_finish <= 1'b1; stub_busy <= 1'b0; end
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one word from the next falling edge and returns just after the
    // rising edge that accepts it; in_valid is left high.
    task automatic push(input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Call at the START-cycle negedge; waits for a fresh finish rise and
    // checks the one-cycle latency to result_valid.
    task automatic await_result(input string tag, input logic [31:0] exp);
        logic prev = tree_finish;
        logic seen = 1'b0;
        logic early_valid = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (tree_finish && !prev) seen = 1'b1;
            else if (result_valid) early_valid = 1'b1;
            prev = tree_finish;
        end
        check({tag, "_finish_seen"}, {127'd0, seen}, 128'd1);
        check({tag, "_no_early_valid"}, {127'd0, early_valid}, 128'd0);
        check({tag, "_valid_at_rise"}, {127'd0, result_valid}, 128'd0);
        @(negedge clk);
        check({tag, "_valid"}, {127'd0, result_valid}, 128'd1);
        check({tag, "_result"}, {96'd0, result}, {96'd0, exp});
    endtask

    task automatic take_result(input string tag);
        @(negedge clk);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check({tag, "_valid_cleared"}, {127'd0, result_valid}, 128'd0);
        check({tag, "_back_to_load"}, {127'd0, in_ready}, 128'd1);
    endtask

    initial begin
        logic [31:0] held;
        logic        bad;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_in_ready", {127'd0, in_ready}, 128'd0);
        check("rst_tree_inputs", tree_inputs, 128'd0);
        check("rst_result_valid", {127'd0, result_valid}, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", {127'd0, in_ready}, 128'd1);
        check("idle_start", {127'd0, tree_start}, 128'd0);

        // Four ones back-to-back, valid held high.
        stub_mode = 0;
        for (int i = 0; i < 4; i++) push(32'h3F800000);
        @(negedge clk);
        check("t1_ready_drop", {127'd0, in_ready}, 128'd0);
        check("t1_start_high", {127'd0, tree_start}, 128'd1);
        check("t1_inputs", tree_inputs, {4{32'h3F800000}});
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_start_pulse", {127'd0, tree_start}, 128'd0);
        check("t1_ready_wait", {127'd0, in_ready}, 128'd0);
        await_result("t1", 32'h40800000);
        take_result("t1");

        // Ascending values with a gap between words 2 and 3, then hold result.
        push(32'h3F800000);
        push(32'h40000000);
        idle();
        idle();
        push(32'h40400000);
        push(32'h40800000);
        @(negedge clk);
        in_valid = 1'b0;
        check("t2_start_high", {127'd0, tree_start}, 128'd1);
        check("t2_inputs", tree_inputs, 128'h3F800000_40000000_40400000_40800000);
        await_result("t2", 32'h41200000);
        held = result;
        bad  = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (!result_valid || result !== held || in_ready) bad = 1'b1;
        end
        check("t3_hold_stable", {127'd0, bad}, 128'd0);
        check("t3_hold_result", {96'd0, result}, {96'd0, 32'h41200000});
        take_result("t3");

        // Tree never finishes: abort after the wait budget.
        stub_mode = 1;
        for (int i = 0; i < 4; i++) push(32'h40400000);
        @(negedge clk);
        in_valid = 1'b0;
        bad = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            if (timeout_err || result_valid) bad = 1'b1;
        end
        @(negedge clk);
        check("t4_no_early_timeout", {127'd0, bad | timeout_err | result_valid}, 128'd0);
        @(negedge clk);
        check("t4_timeout_err", {127'd0, timeout_err}, 128'd1);
        check("t4_no_result", {127'd0, result_valid}, 128'd0);
        check("t4_back_to_load", {127'd0, in_ready}, 128'd1);

        // Next vector completes normally; the error flag stays sticky.
        stub_mode = 0;
        for (int i = 0; i < 4; i++) push(32'h40000000);
        @(negedge clk);
        in_valid = 1'b0;
        await_result("t5", 32'h41000000);
        check("t5_err_sticky", {127'd0, timeout_err}, 128'd1);
        take_result("t5");

        // Leftover finish level: only the second rise completes the run.
        stub_mode = 2;
        check("t6_finish_leftover", {127'd0, tree_finish}, 128'd1);
        for (int i = 0; i < 4; i++) push(32'h3F800000);
        @(negedge clk);
        in_valid = 1'b0;
        await_result("t6", 32'h40800000);
        take_result("t6");

        // Reset mid-load discards the partial vector.
        stub_mode = 0;
        push(32'h40800000);
        push(32'h40800000);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t7_rst_outputs",
              {tree_inputs[95:0], result, in_ready, tree_start, result_valid, timeout_err},
              128'd0);
        check("t7_rst_inputs_msb", {96'd0, tree_inputs[127:96]}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h40000000);
        @(negedge clk);
        in_valid = 1'b0;
        check("t7_inputs", tree_inputs, {4{32'h40000000}});
        await_result("t7", 32'h41000000);
        check("t7_err_cleared", {127'd0, timeout_err}, 128'd0);
        take_result("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
